spi_reg_expander: RTL and testbench

SPI_REG_EXPANDER -- requirements
Module: spi_reg_expander

---
 rtl/spi_exp_pkg.sv | 24 ++
 rtl/spi_exp_sync.sv | 30 +++
 rtl/spi_reg_expander.sv | 160 ++++++++++++++++
 tb/tb_spi_reg_expander.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_exp_pkg.sv
// spi_exp_pkg -- shared definitions for the SPI GPIO register expander.
//   state_t    : frame FSM states; the state names the field of the most
//                recently sampled bit (CMD = RW bit, ADDR, DATA, OVER = extra)
//   REG_OE/REG_OUT/REG_IN : fixed register indices
//   frame_len  : bits in a well-formed frame (RW + address + data)
package spi_exp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_OVER
  } state_t;

  localparam int REG_OE  = 0;
  localparam int REG_OUT = 1;
  localparam int REG_IN  = 2;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_exp_sync.sv
// spi_exp_sync -- two-flop synchronizer for asynchronous pin inputs.
//   clk  : clock
//   rst  : asynchronous active-high reset, clears both stages
//   d_i  : WIDTH-bit asynchronous input
//   q_o  : WIDTH-bit synchronized output, two cycles behind d_i
module spi_exp_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_expander.sv
// spi_reg_expander -- SPI-style serial register file driving GPIO pins.
// Frames are RW bit, address (MSB first), data (MSB first), one bit per clk
// edge while enable=1. A frame is judged at the first edge with enable=0.
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : frame qualifier
//   data       : serial input bit
//   data_out   : serial read data (MSB first)
//   gpio_in    : pin inputs (synchronized into reg2)
//   gpio_out   : pin values from reg1
//   gpio_oe    : pin output enables from reg0
//   frame_err  : one-cycle pulse for a malformed or out-of-range frame
// Optional feature: define SPI_EXP_READBACK_EN to enable serial readback;
// without it data_out is tied 0 and read frames have no effect.
module spi_reg_expander
  import spi_exp_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int N_REGS = 8,
  parameter int N_CH   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            data,
  output logic            data_out,
  input  logic [N_CH-1:0] gpio_in,
  output logic [N_CH-1:0] gpio_out,
  output logic [N_CH-1:0] gpio_oe,
  output logic            frame_err
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  // Counter must hold FRAME_LEN+1 so over-length frames stay distinguishable.
  localparam int CNT_W = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FRAME     = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [ADDR_W:0]  N_REGS_W      = (ADDR_W + 1)'(N_REGS);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                armed_q;   // enable seen low since reset; frames may start
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                frame_err_q;

  logic [N_CH-1:0]          sync_in;
  logic [N_REGS*DATA_W-1:0] reg_flat;
  logic [ADDR_W-1:0]        addr_shift;
  logic                     active;
  logic                     addr_ok;
  logic                     frame_ok;
  logic                     commit;

  spi_exp_sync #(.WIDTH(N_CH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (gpio_in),
    .q_o (sync_in)
  );

  // Address including the bit being sampled this edge.
  assign addr_shift = {addr_q[ADDR_W-2:0], data};
  assign active     = (state_q != ST_IDLE) || armed_q;
  assign addr_ok    = {1'b0, addr_q} < N_REGS_W;
  assign frame_ok   = (cnt_q == CNT_FRAME) && addr_ok;
  assign commit     = !enable && frame_ok && !rw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (!enable) begin
        armed_q <= 1'b1;
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        if (cnt_q != '0 && !frame_ok) frame_err_q <= 1'b1;
      end else if (active) begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        if (cnt_q == '0) begin
          rw_q    <= data;
          state_q <= ST_CMD;
        end else if (cnt_q <= CNT_ADDR_LAST) begin
          addr_q  <= addr_shift;
          state_q <= ST_ADDR;
        end else if (cnt_q < CNT_FRAME) begin
          wdata_q <= {wdata_q[DATA_W-2:0], data};
          state_q <= ST_DATA;
        end else begin
          state_q <= ST_OVER;   // surplus bits are dropped
        end
      end
    end
  end

  // Register file; reg2 is a live view of the synchronized pins.
  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_reg
      if (gi == REG_IN) begin : g_in
        assign reg_flat[gi*DATA_W +: DATA_W] = DATA_W'(sync_in);
      end else begin : g_rw
        logic [DATA_W-1:0] reg_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            reg_q <= (gi == REG_OUT) ? '1 : '0;
          end else if (commit && addr_q == ADDR_W'(gi)) begin
            reg_q <= wdata_q;
          end
        end
        assign reg_flat[gi*DATA_W +: DATA_W] = reg_q;
      end
    end
  endgenerate

  assign gpio_oe   = reg_flat[REG_OE*DATA_W  +: N_CH];
  assign gpio_out  = reg_flat[REG_OUT*DATA_W +: N_CH];
  assign frame_err = frame_err_q;

`ifdef SPI_EXP_READBACK_EN
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] shift_q;

  // Out-of-range addresses match no entry and read as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (addr_shift == ADDR_W'(i)) rd_val = reg_flat[i*DATA_W +: DATA_W];
    end
  end

  // Zero fill on shift means data_out returns to 0 once all data bits left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else if (!enable) begin
      shift_q <= '0;
    end else if (active) begin
      if (cnt_q == CNT_ADDR_LAST) shift_q <= rw_q ? rd_val : '0;
      else                        shift_q <= shift_q << 1;
    end
  end

  assign data_out = shift_q[DATA_W-1];
`else
  logic unused_regs;
  assign unused_regs = ^reg_flat;
  assign data_out    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_expander.sv
module tb_spi_reg_expander;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NR = 8;
  localparam int NCH = 8;
  localparam int FL = 1 + AW + DW;
`ifdef SPI_EXP_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           data;
  logic           data_out;
  logic [NCH-1:0] gpio_in;
  logic [NCH-1:0] gpio_out;
  logic [NCH-1:0] gpio_oe;
  logic           frame_err;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  logic [DW-1:0] m_regs [NR];

  always #5 clk = ~clk;

  spi_reg_expander #(.ADDR_W(AW), .DATA_W(DW), .N_REGS(NR), .N_CH(NCH)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .data      (data),
    .data_out  (data_out),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oe   (gpio_oe),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_regs[1] = '1;
  endtask

  // Register contents as seen by a read; pins are held steady before reads.
  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] addr);
    if (addr >= NR) return '0;
    if (addr == 2) return gpio_in;
    return m_regs[addr];
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      enable = 1'b0;
      data   = 1'b0;
    end
  endtask

  // Send nbits of {rw,addr,wd} (random filler past FL), then end the frame.
  task automatic frame(input string tag, input logic rw, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input int nbits);
    logic [FL-1:0] vec;
    logic [DW-1:0] rv;
    logic          exp_do;
    logic          err;
    vec = {rw, addr, wd};
    rv  = m_read(addr);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      enable = 1'b1;
      data   = (i < FL) ? vec[FL-1-i] : 1'($urandom);
      @(posedge clk);
      #1;
      exp_do = 1'b0;
      if (RB && rw && i >= AW && i < FL - 1) exp_do = rv[DW-1-(i-AW)];
      check({tag, " data_out"}, data_out, exp_do);
      check({tag, " err_mid"}, frame_err, 1'b0);
    end
    @(negedge clk);
    enable = 1'b0;
    data   = 1'b0;
    @(posedge clk);
    #1;
    err = (nbits != 0) && (nbits != FL || addr >= NR);
    if (!err && nbits != 0 && !rw && addr != 2) m_regs[addr] = wd;
    check({tag, " frame_err"}, frame_err, err);
    check({tag, " gpio_oe"}, gpio_oe, m_regs[0]);
    check({tag, " gpio_out"}, gpio_out, m_regs[1]);
    @(posedge clk);
    #1;
    check({tag, " err_pulse"}, frame_err, 1'b0);
    $display("frame %s rw=%0d addr=%02h wd=%02h bits=%0d err=%0d oe=%02h out=%02h",
             tag, rw, addr, wd, nbits, err, gpio_oe, gpio_out);
  endtask

  initial begin
    logic          rr;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    int            nb;
    int            sel;

    rst = 1'b1; enable = 1'b0; data = 1'b0; gpio_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset gpio_oe", gpio_oe, 8'h00);
    check("reset gpio_out", gpio_out, 8'hFF);
    check("reset data_out", data_out, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Short write to reg1: rejected, reg1 keeps its reset value.
    frame("short12", 1'b0, 8'h01, 8'h12, 12);
    check("short12 reg1", gpio_out, 8'hFF);
    // Out-of-range address: rejected, nothing changes.
    frame("addr09", 1'b0, 8'h09, 8'h77, FL);
    check("addr09 oe", gpio_oe, 8'h00);
    // Valid writes to OE and OUT.
    frame("wr_oe", 1'b0, 8'h00, 8'h0F, FL);
    check("wr_oe value", gpio_oe, 8'h0F);
    frame("wr_out", 1'b0, 8'h01, 8'hA5, FL);
    check("wr_out value", gpio_out, 8'hA5);
    // Pin read-back of 0x3C.
    gpio_in = 8'h3C;
    idle(4);
    frame("rd_in", 1'b1, 8'h02, 8'h00, FL);
    // Write to the input register is silently dropped.
    frame("wr_in", 1'b0, 8'h02, 8'hFF, FL);

    // Reset in the middle of a write to reg1.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      enable = 1'b1;
      data   = (i == 0) ? 1'b0 : ((i == 8) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_mid gpio_out", gpio_out, 8'hFF);
    check("rst_mid gpio_oe", gpio_oe, 8'h00);
    check("rst_mid data_out", data_out, 1'b0);
    check("rst_mid frame_err", frame_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    // enable still high after reset: these bits must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      enable = 1'b1;
      data   = 1'($urandom);
      @(posedge clk);
      #1;
      check("post_rst ignored err", frame_err, 1'b0);
    end
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst end err", frame_err, 1'b0);
    check("post_rst gpio_out", gpio_out, 8'hFF);
    $display("frame rst_mid aborted out=%02h", gpio_out);
    frame("wr_out0", 1'b0, 8'h01, 8'h00, FL);
    check("wr_out0 value", gpio_out, 8'h00);

    // Over-length write to scratch reg3 is rejected; reading back gives 0.
    frame("over20", 1'b0, 8'h03, 8'h5A, 20);
    frame("rd_reg3", 1'b1, 8'h03, 8'h00, FL);

    // Randomized frames against the model.
    for (int n = 0; n < 30; n++) begin
      gpio_in = NCH'($urandom);
      idle(3);
      rr  = 1'($urandom);
      ra  = AW'($urandom_range(0, 9));
      rd  = DW'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 7)       nb = FL;
      else if (sel == 7) nb = $urandom_range(0, FL - 1);
      else if (sel == 8) nb = $urandom_range(FL + 1, FL + 5);
      else               nb = 0;
      frame("rand", rr, ra, rd, nb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
